// File: rtl/alu_pkg.sv
// Shared definitions for alu_seq_core: opcode map, compare result codes,
// flag bit positions and FSM state encoding.
package alu_pkg;

  // ALU_FUN opcode map (all operations unsigned)
  localparam logic [3:0] OP_ADD     = 4'b0000;
  localparam logic [3:0] OP_SUB     = 4'b0001;
  localparam logic [3:0] OP_MUL     = 4'b0010;
  localparam logic [3:0] OP_DIV     = 4'b0011;
  localparam logic [3:0] OP_AND     = 4'b0100;
  localparam logic [3:0] OP_OR      = 4'b0101;
  localparam logic [3:0] OP_NAND    = 4'b0110;
  localparam logic [3:0] OP_NOR     = 4'b0111;
  localparam logic [3:0] OP_CMP_NOP = 4'b1000;
  localparam logic [3:0] OP_CMP_EQ  = 4'b1001;
  localparam logic [3:0] OP_CMP_GT  = 4'b1010;
  localparam logic [3:0] OP_CMP_LT  = 4'b1011;
  localparam logic [3:0] OP_SHR_A   = 4'b1100;
  localparam logic [3:0] OP_SHL_A   = 4'b1101;
  localparam logic [3:0] OP_SHR_B   = 4'b1110;
  localparam logic [3:0] OP_SHL_B   = 4'b1111;

  // Result codes produced by the compare unit when the condition holds
  localparam logic [1:0] CMP_EQ_CODE = 2'd1;
  localparam logic [1:0] CMP_GT_CODE = 2'd2;
  localparam logic [1:0] CMP_LT_CODE = 2'd3;

  // Bit positions inside the one-hot unit flag vector
  localparam int FLAG_ARITH = 0;
  localparam int FLAG_LOGIC = 1;
  localparam int FLAG_CMP   = 2;
  localparam int FLAG_SHIFT = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_DIV  = 1'b1
  } state_t;

  // The two opcode MSBs select the unit, so the flag is a simple decode
  function automatic logic [3:0] unit_onehot(input logic [3:0] fun);
    return 4'b0001 << fun[3:2];
  endfunction

endpackage

// File: rtl/alu_div_iter.sv
// Iterative restoring divider: one quotient bit per clock, WIDTH iterations.
// done pulses for one cycle once quotient/remainder are final.
module alu_div_iter #(
  parameter int WIDTH = 16
) (
  input  logic             Clk,
  input  logic             RST,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] rem_reg;
  logic [WIDTH-1:0] quo_reg;
  logic [WIDTH-1:0] dvs_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             busy_reg;
  logic             done_reg;
  logic [WIDTH:0]   trial;

  // Partial remainder shifted left by one bit minus divisor; MSB is the borrow
  assign trial = {rem_reg, quo_reg[WIDTH-1]} - {1'b0, dvs_reg};

  // Load on start, then shift in one quotient bit per cycle until the count expires
  always_ff @(posedge Clk or negedge RST) begin
    if (!RST) begin
      rem_reg  <= '0;
      quo_reg  <= '0;
      dvs_reg  <= '0;
      cnt_reg  <= '0;
      busy_reg <= 1'b0;
      done_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (start && !busy_reg) begin
        rem_reg  <= '0;
        quo_reg  <= A;
        dvs_reg  <= B;
        cnt_reg  <= CNT_W'(WIDTH);
        busy_reg <= 1'b1;
      end else if (busy_reg) begin
        if (trial[WIDTH]) begin
          // Trial subtraction underflowed: restore, quotient bit is 0
          rem_reg <= {rem_reg[WIDTH-2:0], quo_reg[WIDTH-1]};
          quo_reg <= {quo_reg[WIDTH-2:0], 1'b0};
        end else begin
          rem_reg <= trial[WIDTH-1:0];
          quo_reg <= {quo_reg[WIDTH-2:0], 1'b1};
        end
        cnt_reg <= cnt_reg - 1'b1;
        if (cnt_reg == CNT_W'(1)) begin
          busy_reg <= 1'b0;
          done_reg <= 1'b1;
        end
      end
    end
  end

  assign busy      = busy_reg;
  assign done      = done_reg;
  assign quotient  = quo_reg;
  assign remainder = rem_reg;

endmodule

// File: rtl/alu_seq_core.sv
// Handshaked WIDTH-bit ALU: single-cycle add/sub/mul/logic/compare/shift units,
// an iterative divider, and a registered output stage with valid/ready.
module alu_seq_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             Clk,
  input  logic             RST,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALU_FUN,
  input  logic             In_Valid,
  output logic             In_Ready,
  output logic [WIDTH-1:0] Result,
  output logic [WIDTH-1:0] Result_Hi,
  output logic             Carry_OUT,
  output logic             Arith_Flag,
  output logic             Logic_Flag,
  output logic             CMP_Flag,
  output logic             SHIFT_Flag,
  output logic             Div_Err,
  output logic             Out_Valid,
  input  logic             Out_Ready
);

  state_t           state_reg;
  logic             ready_en_reg;
  logic [WIDTH-1:0] result_reg;
  logic [WIDTH-1:0] result_hi_reg;
  logic             carry_reg;
  logic [3:0]       flags_reg;
  logic             div_err_reg;
  logic             out_valid_reg;

  logic [WIDTH:0]     add_full;
  logic [WIDTH:0]     sub_full;
  logic [2*WIDTH-1:0] mul_full;
  logic [WIDTH-1:0]   unit_lo;
  logic [WIDTH-1:0]   unit_hi;
  logic               unit_carry;
  logic               unit_div_err;

  logic             accept;
  logic             is_div;
  logic             div_start;
  logic             div_busy;
  logic             div_done;
  logic [WIDTH-1:0] div_quo;
  logic [WIDTH-1:0] div_rem;

  assign add_full = {1'b0, A} + {1'b0, B};
  assign sub_full = {1'b0, A} - {1'b0, B};
  assign mul_full = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};

  // Single-cycle result for every opcode; the divide entry is only used for B==0
  always_comb begin
    unit_lo      = '0;
    unit_hi      = '0;
    unit_carry   = 1'b0;
    unit_div_err = 1'b0;
    case (ALU_FUN)
      OP_ADD:     begin unit_lo = add_full[WIDTH-1:0]; unit_carry = add_full[WIDTH]; end
      OP_SUB:     begin unit_lo = sub_full[WIDTH-1:0]; unit_carry = sub_full[WIDTH]; end
      OP_MUL:     begin unit_lo = mul_full[WIDTH-1:0]; unit_hi = mul_full[2*WIDTH-1:WIDTH]; end
      OP_DIV:     begin unit_lo = '1; unit_hi = A; unit_div_err = 1'b1; end
      OP_AND:     unit_lo = A & B;
      OP_OR:      unit_lo = A | B;
      OP_NAND:    unit_lo = ~(A & B);
      OP_NOR:     unit_lo = ~(A | B);
      OP_CMP_NOP: unit_lo = '0;
      OP_CMP_EQ:  if (A == B) unit_lo = WIDTH'(CMP_EQ_CODE);
      OP_CMP_GT:  if (A > B)  unit_lo = WIDTH'(CMP_GT_CODE);
      OP_CMP_LT:  if (A < B)  unit_lo = WIDTH'(CMP_LT_CODE);
      OP_SHR_A:   unit_lo = A >> 1;
      OP_SHL_A:   unit_lo = A << 1;
      OP_SHR_B:   unit_lo = B >> 1;
      OP_SHL_B:   unit_lo = B << 1;
      default:    unit_lo = '0;
    endcase
  end

  // Ready only from registered state and the consumer's ready, never from In_Valid
  assign In_Ready  = ready_en_reg && (state_reg == ST_IDLE) && !div_busy &&
                     (!out_valid_reg || Out_Ready);
  assign accept    = In_Valid && In_Ready;
  assign is_div    = (ALU_FUN == OP_DIV);
  assign div_start = accept && is_div && (B != '0);

  alu_div_iter #(
    .WIDTH (WIDTH)
  ) u_div (
    .Clk       (Clk),
    .RST       (RST),
    .start     (div_start),
    .A         (A),
    .B         (B),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  // FSM plus output register; a consume clears the stage unless a new result loads
  always_ff @(posedge Clk or negedge RST) begin
    if (!RST) begin
      state_reg     <= ST_IDLE;
      ready_en_reg  <= 1'b0;
      result_reg    <= '0;
      result_hi_reg <= '0;
      carry_reg     <= 1'b0;
      flags_reg     <= '0;
      div_err_reg   <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      ready_en_reg <= 1'b1;
      if (Out_Ready) begin
        result_reg    <= '0;
        result_hi_reg <= '0;
        carry_reg     <= 1'b0;
        flags_reg     <= '0;
        div_err_reg   <= 1'b0;
        out_valid_reg <= 1'b0;
      end
      case (state_reg)
        ST_IDLE: begin
          if (div_start) begin
            state_reg <= ST_DIV;
          end else if (accept) begin
            result_reg    <= unit_lo;
            result_hi_reg <= unit_hi;
            carry_reg     <= unit_carry;
            flags_reg     <= unit_onehot(ALU_FUN);
            div_err_reg   <= unit_div_err;
            out_valid_reg <= 1'b1;
          end
        end
        ST_DIV: begin
          if (div_done) begin
            state_reg     <= ST_IDLE;
            result_reg    <= div_quo;
            result_hi_reg <= div_rem;
            carry_reg     <= 1'b0;
            flags_reg     <= unit_onehot(OP_DIV);
            div_err_reg   <= 1'b0;
            out_valid_reg <= 1'b1;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign Result     = result_reg;
  assign Result_Hi  = result_hi_reg;
  assign Carry_OUT  = carry_reg;
  assign Arith_Flag = flags_reg[FLAG_ARITH];
  assign Logic_Flag = flags_reg[FLAG_LOGIC];
  assign CMP_Flag   = flags_reg[FLAG_CMP];
  assign SHIFT_Flag = flags_reg[FLAG_SHIFT];
  assign Div_Err    = div_err_reg;
  assign Out_Valid  = out_valid_reg;

endmodule
